pad_input_filter: RTL and testbench
===================================

# pad_input_filter

Synchronises, debounces and edge-detects one asynchronous input-pad signal. Sits directly downstream of an input pad cell: its `pad_in_i` is driven by the pad cell's `pad_out_o`. It feeds a clean level, single-cycle edge pulses and a sticky interrupt to GPIO and peripheral logic in the `clk_i` domain.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of the debounce counter and threshold.
- `SYNC_STAGES`, 2: number of synchroniser flops; legal values are 2 or more.

Ports:
- `clk_i`, input, 1: the single clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `pad_in_i`, input, 1: raw asynchronous value from the pad cell.
- `en_i`, input, 1: filter enable. When 0, debouncing is bypassed.
- `threshold_i`, input, CNT_WIDTH: debounce threshold T, quasi-static.
- `rise_en_i`, input, 1: rising edges set the interrupt.
- `fall_en_i`, input, 1: falling edges set the interrupt.
- `clr_i`, input, 1: one-cycle clear of the interrupt pending bit.
- `level_o`, output, 1: filtered level.
- `rise_o`, output, 1: one-cycle pulse on an accepted 0→1 change.
- `fall_o`, output, 1: one-cycle pulse on an accepted 1→0 change.
- `irq_o`, output, 1: sticky interrupt (the pending bit).

## Operation
- Reset values:
  - sync chain all 0
  - `level_o`=0, `rise_o`=0, `fall_o`=0, `irq_o`=0
  - cnt=0, state=STABLE
- Synchroniser: `pad_in_i` passes through SYNC_STAGES flops. The last stage is `s`. No other logic samples `pad_in_i`.
- FSM, evaluated every cycle with `en_i`=1:
  - STABLE: if `s`==`level_o`, stay and hold cnt=0. Otherwise:
    - if T==0, accept the change this edge;
    - else go to PENDING with cnt=1.
  - PENDING, case `s`==`level_o` (glitch): go to STABLE, cnt=0, no pulse.
  - PENDING, case cnt>=T: accept the change, go to STABLE, cnt=0. The `>=` makes lowering T mid-count take effect at once.
  - PENDING, otherwise: cnt=cnt+1. cnt never exceeds T, so it never wraps.
- Accept means:
  - `level_o` <= `s`.
  - `rise_o` <= `s`, `fall_o` <= !`s`, asserted for exactly that one cycle.
- Net effect: a change is accepted once `s` has differed from `level_o` on T+1 consecutive edges. Shorter excursions are rejected.
- With `en_i`=0:
  - the state is forced to STABLE and cnt to 0;
  - `level_o` <= `s` every edge;
  - edge pulses are still generated on every change.
- Deasserting `en_i` in PENDING discards the count. If `s` still differs, the change is accepted on that edge.
- Interrupt:
  - pend <= (`rise_o`&`rise_en_i`) | (`fall_o`&`fall_en_i`) | (pend & !`clr_i`).
  - A set and `clr_i` in the same cycle leave pend set, so set wins.
  - `irq_o` = pend (registered).

## Timing
- Latency from a `pad_in_i` change to `level_o` is SYNC_STAGES+1+T rising edges, with the pad stable throughout.
  - Example: SYNC_STAGES=2, T=0 gives 3 edges.
- `rise_o`/`fall_o` are high during the first cycle that `level_o` shows the new value.
- `irq_o` rises one cycle after the qualifying `rise_o`/`fall_o`.
- `clr_i` drops `irq_o` on the following cycle, unless a set occurs in the same cycle.
- Async reset mid-count returns every output and state to its reset value immediately. Nothing is pulsed on reset exit.
- If the pad is 1 at reset release, the first accept produces `rise_o`. This is intended.
- Minimum accepted pulse width is T+1 cycles of `s`. A pulse of T cycles or fewer never changes `level_o`.

## Structure
- Package `pad_filter_pkg` holds:
  - `pad_filter_state_e` {STABLE, PENDING};
  - the default-parameter localparams.
- Submodule `pad_sync` is a parameterised SYNC_STAGES flop chain with async active-low reset to 0. It is marked for CDC tooling.
- Top level contains the FSM, counter, edge and interrupt logic.

## Test plan
All cases use SYNC_STAGES=2 unless stated.
- Reset with pad=0, `en_i`=1, T=3; raise pad and hold → `level_o` and `rise_o` go high at edge 6 after the change. `rise_o` lasts 1 cycle.
- T=3; apply a 0→1 glitch of 3 cycles, then back to 0 → `level_o` stays 0, no pulses, cnt returns to 0.
- T=5; hold pad high; at cnt=2 lower T to 1 → accept on the next edge; `rise_o`=1.
- `en_i`=0, T=100; toggle pad every 2 cycles → `level_o` follows `s` with 3-edge latency; `rise_o`/`fall_o` pulse on every change.
- `fall_en_i`=1, `rise_en_i`=0; drive a falling edge, and pulse `clr_i` in the same cycle as `fall_o` → `irq_o`=1 and stays 1. A later `clr_i` alone → `irq_o`=0 the next cycle. A rising edge never sets `irq_o`.
- Assert `rst_ni`=0 while in PENDING with cnt=2 → all outputs 0 immediately. After release with pad=1, `rise_o` occurs after SYNC_STAGES+1+T edges.

Source files
------------

// File: rtl/pad_filter_pkg.sv
// Shared types and default parameters for the pad input filter.
// Imported by the filter top level and by the testbench.
package pad_filter_pkg;

  localparam int unsigned DEF_CNT_WIDTH   = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } pad_filter_state_e;

endpackage

// File: rtl/pad_sync.sv
// CDC synchroniser: a SYNC_STAGES-deep flop chain for one asynchronous bit.
// This is the only place the raw pad value is sampled; the chain resets to 0.
module pad_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pad_input_filter.sv
// Synchronises, debounces and edge-detects one pad input, producing a clean
// level, single-cycle edge pulses and a sticky interrupt.
module pad_input_filter
  import pad_filter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pad_in_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] threshold_i,
  input  logic                 rise_en_i,
  input  logic                 fall_en_i,
  input  logic                 clr_i,
  output logic                 level_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 irq_o
);

  logic s;

  pad_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pad_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (pad_in_i),
    .q_o   (s)
  );

  pad_filter_state_e    state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 pend_q, pend_d;
  logic                 accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;

    if (!en_i) begin
      // Bypass: any pending count is discarded and a difference is taken now.
      state_d = STABLE;
      cnt_d   = '0;
      accept  = (s != level_q);
    end else begin
      case (state_q)
        STABLE: begin
          cnt_d = '0;
          if (s != level_q) begin
            if (threshold_i == '0) begin
              accept = 1'b1;
            end else begin
              state_d = PENDING;
              cnt_d   = CNT_WIDTH'(1);
            end
          end
        end
        PENDING: begin
          if (s == level_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q >= threshold_i) begin
            // >= lets a lowered threshold take effect mid-count.
            accept  = 1'b1;
            state_d = STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    level_d = accept ? s : level_q;
    rise_d  = accept & s;
    fall_d  = accept & ~s;
    // A new set beats a simultaneous clear.
    pend_d  = (rise_q & rise_en_i) | (fall_q & fall_en_i) | (pend_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign irq_o   = pend_q;

endmodule

// File: tb/tb_pad_input_filter.sv
// Directed bench for pad_input_filter: a per-cycle vector table plus
// hand-written sequences for glitches, threshold change, interrupt and reset.
module tb_pad_input_filter;
  import pad_filter_pkg::*;

  localparam int unsigned CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          pad_in_i = 1'b0;
  logic          en_i = 1'b1;
  logic [CW-1:0] threshold_i = 16'd3;
  logic          rise_en_i = 1'b1;
  logic          fall_en_i = 1'b1;
  logic          clr_i = 1'b0;
  logic          level_o, rise_o, fall_o, irq_o;

  int checks = 0;
  int failures = 0;

  pad_input_filter #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .pad_in_i   (pad_in_i),
    .en_i       (en_i),
    .threshold_i(threshold_i),
    .rise_en_i  (rise_en_i),
    .fall_en_i  (fall_en_i),
    .clr_i      (clr_i),
    .level_o    (level_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .irq_o      (irq_o)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          pad;
    logic          en;
    logic [CW-1:0] thr;
    logic          clr;
    logic          level;
    logic          rise;
    logic          fall;
    logic          irq;
  } vec_t;

  vec_t vecs[20];

  // Driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic pad, input logic [CW-1:0] thr,
                          input logic ren, input logic fen);
    rst_ni      = 1'b0;
    pad_in_i    = pad;
    en_i        = 1'b1;
    threshold_i = thr;
    rise_en_i   = ren;
    fall_en_i   = fen;
    clr_i       = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input logic lv, input logic ri,
                               input logic fa, input logic iq);
    check({tag, "_level"}, 32'(level_o), 32'(lv));
    check({tag, "_rise"},  32'(rise_o),  32'(ri));
    check({tag, "_fall"},  32'(fall_o),  32'(fa));
    check({tag, "_irq"},   32'(irq_o),   32'(iq));
  endtask

  initial begin
    int rises;
    int falls;
    int edge_no;
    int rise_edge;
    bit seen;

    // pad, en, thr, clr | level, rise, fall, irq
    vecs[0]  = '{1'b1, 1'b1, 16'd3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 16'd3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'd3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 16'd3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'd3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 16'd3,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'd3,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 16'd3,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'd100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'd100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'd100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 16'd100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 16'd100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 16'd100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 16'd100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 16'd100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 16'd100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 16'd3,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset values while held in reset
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_cnt", 32'(dut.cnt_q), 32'd0);
    do_reset(1'b0, 16'd3, 1'b1, 1'b1);
    step();
    check_outputs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Table: T=3 debounced rise, irq set/clear, then bypass toggling
    for (int i = 0; i < 20; i++) begin
      pad_in_i    = vecs[i].pad;
      en_i        = vecs[i].en;
      threshold_i = vecs[i].thr;
      clr_i       = vecs[i].clr;
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].level, vecs[i].rise,
                    vecs[i].fall, vecs[i].irq);
    end
    clr_i = 1'b0;

    // Glitch of T cycles is rejected, T+1 cycles is accepted
    do_reset(1'b0, 16'd3, 1'b1, 1'b1);
    pad_in_i = 1'b1;
    repeat (3) step();
    pad_in_i = 1'b0;
    rises = 0;
    falls = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rise_o) rises++;
      if (fall_o) falls++;
      check($sformatf("glitch3_level_c%0d", i), 32'(level_o), 32'd0);
    end
    check("glitch3_pulses", 32'(rises + falls), 32'd0);
    check("glitch3_cnt", 32'(dut.cnt_q), 32'd0);
    check("glitch3_state", 32'(dut.state_q), 32'(STABLE));

    pad_in_i = 1'b1;
    repeat (4) step();
    pad_in_i = 1'b0;
    rises = 0;
    falls = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (rise_o) rises++;
      if (fall_o) falls++;
    end
    check("pulse4_rises", 32'(rises), 32'd1);
    check("pulse4_falls", 32'(falls), 32'd1);
    check("pulse4_level", 32'(level_o), 32'd0);

    // Lowering T mid-count accepts on the next edge
    do_reset(1'b0, 16'd5, 1'b1, 1'b1);
    pad_in_i = 1'b1;
    repeat (4) step();
    check("lower_t_cnt", 32'(dut.cnt_q), 32'd2);
    check("lower_t_level_before", 32'(level_o), 32'd0);
    threshold_i = 16'd1;
    step();
    check("lower_t_level", 32'(level_o), 32'd1);
    check("lower_t_rise", 32'(rise_o), 32'd1);

    // Interrupt: falls only; set wins over same-cycle clear
    do_reset(1'b0, 16'd0, 1'b0, 1'b1);
    pad_in_i = 1'b1;
    repeat (5) step();
    check("irq_rise_level", 32'(level_o), 32'd1);
    check("irq_rise_no_irq", 32'(irq_o), 32'd0);
    pad_in_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (fall_o) seen = 1'b1;
    end
    check("irq_fall_seen", 32'(seen), 32'd1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("irq_set_wins", 32'(irq_o), 32'd1);
    repeat (3) step();
    check("irq_sticky", 32'(irq_o), 32'd1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("irq_cleared", 32'(irq_o), 32'd0);
    pad_in_i = 1'b1;
    repeat (5) step();
    check("irq_rise_disabled", 32'(irq_o), 32'd0);

    // Async reset mid-count, then re-accept with pad high
    do_reset(1'b0, 16'd3, 1'b1, 1'b1);
    pad_in_i = 1'b1;
    repeat (4) step();
    check("rst_mid_cnt", 32'(dut.cnt_q), 32'd2);
    check("rst_mid_state", 32'(dut.state_q), 32'(PENDING));
    #1;
    rst_ni = 1'b0;
    #1;
    check_outputs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_cnt_cleared", 32'(dut.cnt_q), 32'd0);
    check("rst_mid_state_cleared", 32'(dut.state_q), 32'(STABLE));
    @(negedge clk_i);
    rst_ni = 1'b1;
    rise_edge = 0;
    for (edge_no = 1; edge_no <= 20 && rise_edge == 0; edge_no++) begin
      step();
      if (rise_o) rise_edge = edge_no;
    end
    check("rst_release_latency", 32'(rise_edge), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
